imem_loader: RTL and testbench

Byte-stream program loader that writes instruction words into the instruction memory port read by the single-cycle RISC-V core. It accepts a length-prefixed little-endian byte stream over a valid/ready handshake, packs bytes into 32-bit instructions, and issues one write per word at consecutive word addresses. It holds the core in reset while loading and releases it when the last word is written.

---
 rtl/imem_loader.sv | 139 +++++++++++++
 tb/tb_imem_loader.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// Loads a length-prefixed little-endian byte stream into instruction memory,
// holding the core in reset until the last word has been written.
module imem_loader #(
   parameter int          MAX_WORDS = 64,
   parameter logic [63:0] BASE_ADDR = 64'd0
) (
   input  logic        clk_i,
   input  logic        reset_i,
   input  logic        load_start_i,
   input  logic        byte_valid_i,
   input  logic [7:0]  byte_data_i,
   output logic        byte_ready_o,
   output logic        imem_we_o,
   output logic [63:0] imem_addr_o,
   output logic [31:0] imem_wdata_o,
   output logic        core_reset_o,
   output logic        done_o,
   output logic        error_o,
   output logic [15:0] words_loaded_o
);
   typedef enum logic [2:0] {S_IDLE, S_HDR0, S_HDR1, S_LOAD, S_DONE, S_ERROR} state_t;

   localparam logic [16:0] MAXW = 17'(MAX_WORDS);

   state_t      state_q, state_d;
   logic [15:0] cnt_q, cnt_d;
   logic [15:0] wl_q, wl_d;
   logic [1:0]  idx_q, idx_d;
   logic [23:0] part_q, part_d;
   logic        we_q, we_d;
   logic [63:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic        core_reset_q, core_reset_d;
   logic        done_q, done_d;
   logic        error_q, error_d;
   logic        xfer;
   logic [15:0] hdr_cnt;

   assign xfer    = byte_valid_i && byte_ready_o;
   assign hdr_cnt = {byte_data_i, cnt_q[7:0]};

   always_ff @(posedge clk_i) begin
      if (reset_i) state_q <= S_IDLE;
      else         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (load_start_i) state_d = S_HDR0;
         S_HDR0:  if (xfer) state_d = S_HDR1;
         S_HDR1: begin
            if (xfer) begin
               if (hdr_cnt == 16'd0)            state_d = S_DONE;
               else if ({1'b0, hdr_cnt} > MAXW) state_d = S_ERROR;
               else                             state_d = S_LOAD;
            end
         end
         S_LOAD:  if (xfer && idx_q == 2'd3 && wl_q == cnt_q - 16'd1) state_d = S_DONE;
         S_DONE:  if (load_start_i) state_d = S_HDR0;
         S_ERROR: state_d = S_ERROR;
         default: state_d = S_IDLE;
      endcase
   end

   // Status flags are registered copies of the next state, so release lines
   // up with the final write strobe.
   always_comb begin
      byte_ready_o = (state_q == S_HDR0) || (state_q == S_HDR1) || (state_q == S_LOAD);
      cnt_d        = cnt_q;
      wl_d         = wl_q;
      idx_d        = idx_q;
      part_d       = part_q;
      we_d         = 1'b0;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      done_d       = (state_d == S_DONE);
      core_reset_d = (state_d != S_DONE);
      error_d      = (state_d == S_ERROR);
      case (state_q)
         S_HDR0: if (xfer) cnt_d = {cnt_q[15:8], byte_data_i};
         S_HDR1: begin
            if (xfer) begin
               cnt_d = hdr_cnt;
               wl_d  = 16'd0;
               idx_d = 2'd0;
            end
         end
         S_LOAD: begin
            if (xfer) begin
               idx_d  = idx_q + 2'd1;
               part_d = {byte_data_i, part_q[23:8]};
               if (idx_q == 2'd3) begin
                  we_d    = 1'b1;
                  wdata_d = {byte_data_i, part_q};
                  addr_d  = BASE_ADDR + {46'd0, wl_q, 2'b00};
                  wl_d    = wl_q + 16'd1;
               end
            end
         end
         S_DONE:  if (load_start_i) wl_d = 16'd0;
         default: ;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         cnt_q        <= '0;
         wl_q         <= '0;
         idx_q        <= '0;
         part_q       <= '0;
         we_q         <= 1'b0;
         addr_q       <= BASE_ADDR;
         wdata_q      <= '0;
         core_reset_q <= 1'b1;
         done_q       <= 1'b0;
         error_q      <= 1'b0;
      end else begin
         cnt_q        <= cnt_d;
         wl_q         <= wl_d;
         idx_q        <= idx_d;
         part_q       <= part_d;
         we_q         <= we_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         core_reset_q <= core_reset_d;
         done_q       <= done_d;
         error_q      <= error_d;
      end
   end

   assign imem_we_o      = we_q;
   assign imem_addr_o    = addr_q;
   assign imem_wdata_o   = wdata_q;
   assign core_reset_o   = core_reset_q;
   assign done_o         = done_q;
   assign error_o        = error_q;
   assign words_loaded_o = wl_q;
endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: directed and randomized loads compared against
// a word-list reference model of the byte stream.
module tb_imem_loader;
   localparam int          MAXW = 64;
   localparam logic [63:0] BASE = 64'd0;

   logic        clk = 1'b0, reset = 1'b1, load_start = 1'b0, byte_valid = 1'b0;
   logic [7:0]  byte_data = 8'h00;
   logic        byte_ready, imem_we, core_reset, done, error;
   logic [63:0] imem_addr;
   logic [31:0] imem_wdata;
   logic [15:0] words_loaded;

   int tests = 0, fails = 0;
   int hdr_left, pay, nstr;
   bit last_xfer;
   logic [31:0] exp_w[$];
   logic [63:0] obs_a[$];
   logic [31:0] obs_d[$];

   imem_loader #(.MAX_WORDS(MAXW), .BASE_ADDR(BASE)) dut (
      .clk_i(clk), .reset_i(reset), .load_start_i(load_start),
      .byte_valid_i(byte_valid), .byte_data_i(byte_data), .byte_ready_o(byte_ready),
      .imem_we_o(imem_we), .imem_addr_o(imem_addr), .imem_wdata_o(imem_wdata),
      .core_reset_o(core_reset), .done_o(done), .error_o(error),
      .words_loaded_o(words_loaded)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One clock: drive inputs, note whether a byte transfers, sample after the edge.
   task automatic step(input logic ls, input logic v, input logic [7:0] d);
      load_start = ls;
      byte_valid = v;
      byte_data  = d;
      last_xfer  = v && byte_ready && !reset;
      @(posedge clk);
      #1;
      load_start = 1'b0;
      byte_valid = 1'b0;
      if (last_xfer) begin
         if (hdr_left > 0) hdr_left--;
         else pay++;
      end
      if (imem_we === 1'b1) begin
         nstr++;
         obs_a.push_back(imem_addr);
         obs_d.push_back(imem_wdata);
         chk("strobe_follows_word", {62'd0, (pay % 4) == 0, nstr == pay / 4}, 64'd3);
      end
   endtask

   // mode 0: valid every cycle, 1: valid toggles, 2: random valid
   task automatic run_load(input int mode);
      logic [7:0] s[$];
      int n, w;
      bit tg, v;
      n = exp_w.size();
      s.push_back(8'(n));
      s.push_back(8'(n >> 8));
      foreach (exp_w[i]) for (int b = 0; b < 4; b++) s.push_back(exp_w[i][8*b +: 8]);
      obs_a.delete(); obs_d.delete();
      hdr_left = 2; pay = 0; nstr = 0; tg = 1'b1;
      step(1'b1, 1'b0, 8'h00);
      chk("start_core_reset", core_reset, 1);
      chk("start_done", done, 0);
      chk("start_words", words_loaded, 0);
      chk("start_ready", byte_ready, 1);
      foreach (s[k]) begin
         w = 0;
         do begin
            if (mode == 0) v = 1'b1;
            else if (mode == 1) begin v = tg; tg = !tg; end
            else v = ($urandom_range(0, 2) != 0);
            step(1'b0, v, s[k]);
            if (!last_xfer) begin
               w++;
               if (w > 50) begin
                  chk("byte_timeout", 0, 1);
                  return;
               end
            end
         end while (!last_xfer);
         if (k < s.size() - 1) chk("busy_reset_done", {62'd0, core_reset, done}, 64'd2);
      end
      chk("final_we", imem_we, (n > 0) ? 1 : 0);
      chk("release_core_reset", core_reset, 0);
      chk("release_done", done, 1);
      chk("final_words", words_loaded, n);
      step(1'b0, 1'b1, 8'($urandom));
      chk("strobe_one_cycle", imem_we, 0);
      chk("done_ready_low", byte_ready, 0);
      chk("done_hold", done, 1);
      chk("write_count", obs_a.size(), n);
      for (int i = 0; i < n && i < obs_a.size(); i++) begin
         chk("wr_addr", obs_a[i], BASE + 64'(4 * i));
         chk("wr_data", obs_d[i], exp_w[i]);
      end
   endtask

   initial begin
      hdr_left = 0; pay = 0; nstr = 0;
      reset = 1'b1;
      step(1'b0, 1'b0, 8'h00);
      step(1'b1, 1'b1, 8'h00);
      chk("rst_ready", byte_ready, 0);
      chk("rst_we", imem_we, 0);
      chk("rst_addr", imem_addr, BASE);
      chk("rst_wdata", imem_wdata, 0);
      chk("rst_core_reset", core_reset, 1);
      chk("rst_done", done, 0);
      chk("rst_error", error, 0);
      chk("rst_words", words_loaded, 0);
      reset = 1'b0;
      step(1'b0, 1'b1, 8'h00);
      chk("idle_ready", byte_ready, 0);

      exp_w = {32'h00A00513, 32'h00100593};
      run_load(0);
      exp_w = {32'h00A00513, 32'h00100593};
      run_load(1);
      exp_w.delete();
      run_load(0);
      exp_w = {32'hDEADBEEF};
      run_load(0);
      repeat (4) begin
         exp_w.delete();
         repeat ($urandom_range(1, 6)) exp_w.push_back($urandom);
         run_load(2);
      end
      exp_w.delete();
      repeat (MAXW) exp_w.push_back($urandom);
      run_load(0);

      // reset partway through a 4-word load
      obs_a.delete(); obs_d.delete();
      hdr_left = 2; pay = 0; nstr = 0;
      step(1'b1, 1'b0, 8'h00);
      step(1'b0, 1'b1, 8'h04);
      step(1'b0, 1'b1, 8'h00);
      repeat (6) step(1'b0, 1'b1, 8'($urandom));
      chk("midload_strobes", nstr, 1);
      reset = 1'b1;
      step(1'b0, 1'b1, 8'h55);
      reset = 1'b0;
      chk("midrst_ready", byte_ready, 0);
      chk("midrst_core_reset", core_reset, 1);
      chk("midrst_we", imem_we, 0);
      chk("midrst_words", words_loaded, 0);
      chk("midrst_done", done, 0);
      repeat (8) step(1'b0, 1'b1, 8'($urandom));
      chk("midrst_no_writes", nstr, 1);
      exp_w.delete();
      repeat (2) exp_w.push_back($urandom);
      run_load(2);

      // header count of MAX_WORDS+1
      hdr_left = 2; pay = 0; nstr = 0;
      step(1'b1, 1'b0, 8'h00);
      step(1'b0, 1'b1, 8'(MAXW + 1));
      step(1'b0, 1'b1, 8'((MAXW + 1) >> 8));
      chk("err_flag", error, 1);
      chk("err_ready", byte_ready, 0);
      chk("err_core_reset", core_reset, 1);
      chk("err_done", done, 0);
      repeat (3) step(1'b1, 1'b1, 8'($urandom));
      chk("err_sticky", error, 1);
      chk("err_sticky_ready", byte_ready, 0);
      chk("err_no_writes", nstr, 0);
      reset = 1'b1;
      step(1'b0, 1'b0, 8'h00);
      reset = 1'b0;
      chk("err_cleared", error, 0);
      chk("err_rst_core_reset", core_reset, 1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
